// File: rtl/data_mem_bist.sv
// ----------------------------------------------------------------------------
// data_mem_bist
//   March-style self-test of a word-addressed data memory. It writes PATTERN
//   to every word, then interleaves (read PATTERN, write ~PATTERN) per word,
//   then reads ~PATTERN back from every word. It counts mismatches and keeps
//   the address and data of the first one.
//
// Ports
//   clk        - system clock, rising edge
//   reset      - asynchronous reset, active low
//   start      - one-cycle run request (ignored while busy)
//   base_addr  - byte address of the first tested word, sampled on accepted start
//   WE/A/WD    - memory write enable, byte address and write data (registered)
//   RD         - memory read data, combinational from A
//   busy       - run in progress
//   done       - run finished, results valid until next accepted start
//   pass       - valid with done: no mismatches seen
//   err_count  - saturating mismatch count
//   fail_addr  - address of the first mismatch
//   fail_data  - RD value at the first mismatch
//
// state | meaning
// IDLE  | waiting for start, memory bus parked at zero
// WR_P  | write PATTERN to every word
// RD_P  | read word i, expect PATTERN
// WR_N  | write ~PATTERN to word i
// RD_N  | read every word, expect ~PATTERN
// DONE  | results held, waiting for start
// ----------------------------------------------------------------------------
module data_mem_bist #(
    parameter int          WORDS   = 64,
    parameter logic [31:0] PATTERN = 32'hA5A55A5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] WD,
    input  logic [31:0] RD,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data
);

    typedef enum logic [2:0] {IDLE, WR_P, RD_P, WR_N, RD_N, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  err_q, err_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;
    logic        we_q, we_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic        last;
    logic        cmp_en;
    logic [31:0] exp_data;
    logic        run_d;

    assign last = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        cmp_en      = 1'b0;
        exp_data    = PATTERN;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d      = base_addr;
                    err_d       = 8'd0;
                    fail_addr_d = 32'd0;
                    fail_data_d = 32'd0;
                    idx_d       = 8'd0;
                    state_d     = WR_P;
                end
            end
            WR_P: begin
                if (last) begin
                    idx_d   = 8'd0;
                    state_d = RD_P;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            RD_P: begin
                cmp_en  = 1'b1;
                state_d = WR_N;
            end
            WR_N: begin
                if (last) begin
                    idx_d   = 8'd0;
                    state_d = RD_N;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_P;
                end
            end
            RD_N: begin
                cmp_en   = 1'b1;
                exp_data = ~PATTERN;
                if (last) state_d = DONE;
                else      idx_d   = idx_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // First-failure capture keys off the count before this increment.
        if (cmp_en && (RD != exp_data)) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'd0) begin
                fail_addr_d = a_q;
                fail_data_d = RD;
            end
        end

        // Bus outputs are computed from the next state so they register
        // in step with it.
        run_d  = (state_d == WR_P) || (state_d == RD_P) ||
                 (state_d == WR_N) || (state_d == RD_N);
        a_d    = run_d ? (base_d + {22'd0, idx_d, 2'b00}) : 32'd0;
        we_d   = (state_d == WR_P) || (state_d == WR_N);
        wd_d   = (state_d == WR_P) ? PATTERN :
                 (state_d == WR_N) ? ~PATTERN : 32'd0;
        busy_d = run_d;
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            base_q      <= 32'd0;
            err_q       <= 8'd0;
            fail_addr_q <= 32'd0;
            fail_data_q <= 32'd0;
            we_q        <= 1'b0;
            a_q         <= 32'd0;
            wd_q        <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            we_q        <= we_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign WE        = we_q;
    assign A         = a_q;
    assign WD        = wd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule
